// File: rtl/dac_wave_player.sv
// Steps through a waveform ROM with a programmable stride and drives the DAC code.
// Define DAC_WAVE_GAIN_EN to add a 2-bit arithmetic attenuation input (gain).
module dac_wave_player #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int TABLE_LEN = 2000,
  parameter int STEP_W    = 8,
  parameter int STEP_RST  = 2,
  parameter int ROM_LAT   = 1,
  parameter int DISP_DIV  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              step_up,
  input  logic              step_down,
`ifdef DAC_WAVE_GAIN_EN
  input  logic [1:0]        gain,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] dac_value,
  output logic              dac_valid,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] disp_sample,
  output logic              disp_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int AW1 = ADDR_W + 1;
  localparam int CW  = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

  localparam logic [AW1-1:0]    LEN  = AW1'(TABLE_LEN);
  localparam logic [AW1-1:0]    LAST = AW1'(TABLE_LEN - 1);
  localparam logic [STEP_W-1:0] SMAX = '1;
  localparam logic [STEP_W-1:0] SMIN = STEP_W'(1);
  localparam logic [DATA_W-1:0] MID  = DATA_W'(2 ** (DATA_W - 1));
  localparam logic [CW-1:0]     CTOP = CW'(DISP_DIV - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              dir_q;
  logic              dir_d;
  logic              push;

  logic [AW1-1:0] a_ext;
  logic [AW1-1:0] s_ext;
  logic [AW1-1:0] sum;
  logic [AW1-1:0] wrap;
  logic [AW1-1:0] back;

  logic pp;
  logic os;

  logic [ROM_LAT:0]  pipe;
  logic              load;
  logic [DATA_W-1:0] dac_d;
  logic [CW-1:0]     cnt;

  assign a_ext = AW1'(rom_addr);
  assign s_ext = AW1'(step);
  assign sum   = a_ext + s_ext;
  assign wrap  = sum - LEN;
  assign back  = a_ext - s_ext;

  assign pp = (mode == 2'b10);
  assign os = (mode == 2'b01);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stop dominates start; a tick in the same cycle as either is dropped
  always_comb begin
    state_d = state_q;
    addr_d  = rom_addr;
    dir_d   = pp ? dir_q : 1'b0;
    push    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      dir_d   = 1'b0;
    end else if (start) begin
      state_d = RUN;
      addr_d  = '0;
      dir_d   = 1'b0;
    end else if (state_q == RUN && sample_tick) begin
      unique case (1'b1)
        pp && !dir_q: begin
          push = 1'b1;
          if (sum >= LAST) begin
            addr_d = LAST[ADDR_W-1:0];
            dir_d  = 1'b1;
          end else begin
            addr_d = sum[ADDR_W-1:0];
          end
        end
        pp && dir_q: begin
          push = 1'b1;
          if (a_ext <= s_ext) begin
            addr_d = '0;
            dir_d  = 1'b0;
          end else begin
            addr_d = back[ADDR_W-1:0];
          end
        end
        os: begin
          if (sum >= LEN) begin
            state_d = DONE;
          end else begin
            addr_d = sum[ADDR_W-1:0];
            push   = 1'b1;
          end
        end
        default: begin
          push = 1'b1;
          if (sum >= LEN) begin
            addr_d = wrap[ADDR_W-1:0];
          end else begin
            addr_d = sum[ADDR_W-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      dir_q    <= 1'b0;
    end else begin
      rom_addr <= addr_d;
      dir_q    <= dir_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= STEP_W'(STEP_RST);
    end else if (step_up && !step_down) begin
      if (step != SMAX) begin
        step <= step + SMIN;
      end
    end else if (step_down && !step_up) begin
      if (step > SMIN) begin
        step <= step - SMIN;
      end
    end
  end

  // one bit per in-flight sample; bit ROM_LAT lines up with valid rom_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (stop) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[ROM_LAT-1:0], push};
    end
  end

  assign load = pipe[ROM_LAT] && !stop;

`ifdef DAC_WAVE_GAIN_EN
  localparam logic [DATA_W:0] MIDX = (DATA_W + 1)'(2 ** (DATA_W - 1));

  logic signed [DATA_W:0] centred;
  logic signed [DATA_W:0] scaled;
  logic        [DATA_W:0] mixed;

  assign centred = $signed({1'b0, rom_q} - MIDX);
  assign scaled  = centred >>> gain;
  assign mixed   = MIDX + $unsigned(scaled);
  assign dac_d   = mixed[DATA_W-1:0];
`else
  assign dac_d = rom_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_value <= MID;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= load;
      if (load) begin
        dac_value <= dac_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      disp_sample <= '0;
      disp_valid  <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (start) begin
        cnt <= '0;
      end else if (load) begin
        if (cnt == CTOP) begin
          cnt         <= '0;
          disp_sample <= dac_d;
          disp_valid  <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: address model, step model and a
// scoreboard of expected DAC samples checked as the DUT emits them.
module tb_dac_wave_player;

  typedef struct {
    logic [7:0] v;
    int         due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic        step_up;
  logic        step_down;
  logic [1:0]  gain;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  dac_value;
  logic        dac_valid;
  logic [7:0]  step;
  logic        busy;
  logic        done;
  logic [7:0]  disp_sample;
  logic        disp_valid;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int nvalid  = 0;
  int ndisp   = 0;
  int dcnt    = 0;
  int base;

  int m_state = 0;
  int m_addr  = 0;
  int m_step  = 2;
  int m_mode  = 0;
  int m_dir   = 0;

  exp_t sb[$];
  exp_t mon_e;

  dac_wave_player dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .step_up     (step_up),
    .step_down   (step_down),
`ifdef DAC_WAVE_GAIN_EN
    .gain        (gain),
`endif
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .dac_value   (dac_value),
    .dac_valid   (dac_valid),
    .step        (step),
    .busy        (busy),
    .done        (done),
    .disp_sample (disp_sample),
    .disp_valid  (disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] rom_val(input int a);
    if (a == 5) return 8'hFF;
    return 8'(a * 37 + (a >> 3));
  endfunction

  function automatic logic [7:0] gain_apply(input logic [7:0] q,
                                            input logic [1:0] g);
    int c;
    c = int'(q) - 128;
    c = c >>> g;
    return 8'(c + 128);
  endfunction

  // synchronous ROM, one cycle of read latency
  always @(posedge clk) rom_q <= rom_val(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dac_valid) begin
        if (sb.size() == 0) begin
          chk("dac_valid_unexpected", 32'(dac_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          nvalid++;
          dcnt++;
          chk("dac_value", 32'(dac_value), 32'(mon_e.v));
          chk("dac_cycle", cyc, mon_e.due);
          chk("disp_valid", 32'(disp_valid), 32'(dcnt == 64));
          if (dcnt == 64) begin
            chk("disp_sample", 32'(disp_sample), 32'(mon_e.v));
            dcnt = 0;
          end
        end
      end else if (disp_valid) begin
        chk("disp_valid_stray", 32'(disp_valid), 32'd0);
      end
      if (disp_valid) ndisp++;
    end
  end

  task automatic tick();
    int s;
    int a;
    logic emit;
    s = m_step;
    a = m_addr;
    emit = 1'b0;
    if (m_state == 1) begin
      case (m_mode)
        1: begin
          if (a + s >= 2000) m_state = 2;
          else begin
            m_addr = a + s;
            emit = 1'b1;
          end
        end
        2: begin
          emit = 1'b1;
          if (m_dir == 0) begin
            if (a + s >= 1999) begin
              m_addr = 1999;
              m_dir = 1;
            end else m_addr = a + s;
          end else begin
            if (a <= s) begin
              m_addr = 0;
              m_dir = 0;
            end else m_addr = a - s;
          end
        end
        default: begin
          emit = 1'b1;
          m_addr = (a + s >= 2000) ? a + s - 2000 : a + s;
        end
      endcase
    end
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    if (emit) sb.push_back('{gain_apply(rom_val(m_addr), gain), cyc + 2});
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_step(input logic up, input logic dn);
    step_up = up;
    step_down = dn;
    @(posedge clk);
    #1;
    step_up = 1'b0;
    step_down = 1'b0;
    if (up && !dn && m_step < 255) m_step++;
    if (dn && !up && m_step > 1) m_step--;
    chk("step", 32'(step), 32'(m_step));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_state = 1;
    m_addr = 0;
    m_dir = 0;
    dcnt = 0;
    chk("start_addr", 32'(rom_addr), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_stop(input logic with_start);
    stop = 1'b1;
    start = with_start;
    @(posedge clk);
    #1;
    stop = 1'b0;
    start = 1'b0;
    m_state = 0;
    m_addr = 0;
    sb.delete();
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_addr", 32'(rom_addr), 32'd0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    m_mode = (m == 2'b11) ? 0 : int'(m);
    if (m_mode != 2) m_dir = 0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sample_tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode = 2'b00;
    step_up = 1'b0;
    step_down = 1'b0;
    gain = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_dac", 32'(dac_value), 32'h80);
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_step", 32'(step), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_disp", 32'(disp_sample), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) pulse_step(1'b1, 1'b0);
    chk("step_sat_hi", 32'(step), 32'd255);
    for (int i = 0; i < 300; i++) pulse_step(1'b0, 1'b1);
    chk("step_sat_lo", 32'(step), 32'd1);
    pulse_step(1'b1, 1'b1);

    repeat (3) pulse_step(1'b1, 1'b0);
    set_mode(2'b00);
    do_start();
    ticks(250);
    chk("pre_rst_addr", 32'(rom_addr), 32'h3E8);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_state = 0;
    m_addr = 0;
    m_step = 2;
    m_dir = 0;
    dcnt = 0;
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_dac", 32'(dac_value), 32'h80);
    chk("arst_step", 32'(step), 32'd2);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(dac_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    pulse_step(1'b1, 1'b0);
    do_start();
    ticks(666);
    chk("cont_addr_1998", 32'(rom_addr), 32'd1998);
    tick();
    chk("cont_wrap", 32'(rom_addr), 32'd1);
    drain();
    do_stop(1'b0);

    base = ndisp;
    do_start();
    ticks(130);
    drain();
    chk("disp_pulses", 32'(ndisp - base), 32'd2);
    do_stop(1'b0);

    pulse_step(1'b0, 1'b1);
    set_mode(2'b01);
    do_start();
    base = nvalid;
    ticks(1000);
    chk("os_done", 32'(done), 32'd1);
    chk("os_busy", 32'(busy), 32'd0);
    chk("os_addr", 32'(rom_addr), 32'd1998);
    ticks(5);
    drain();
    chk("os_samples", 32'(nvalid - base), 32'd999);
    chk("os_frozen", 32'(rom_addr), 32'd1998);
    do_start();
    chk("os_restart_done", 32'(done), 32'd0);
    do_stop(1'b0);

    repeat (2) pulse_step(1'b1, 1'b0);
    set_mode(2'b10);
    do_start();
    ticks(499);
    chk("pp_1996", 32'(rom_addr), 32'd1996);
    tick();
    chk("pp_top", 32'(rom_addr), 32'd1999);
    tick();
    chk("pp_1995", 32'(rom_addr), 32'd1995);
    tick();
    chk("pp_1991", 32'(rom_addr), 32'd1991);
    ticks(497);
    chk("pp_3", 32'(rom_addr), 32'd3);
    tick();
    chk("pp_bottom", 32'(rom_addr), 32'd0);
    tick();
    chk("pp_forward", 32'(rom_addr), 32'd4);
    drain();

    do_stop(1'b1);
    ticks(3);
    drain();

    set_mode(2'b11);
    do_start();
    ticks(10);
    drain();
    tick();
    tick();
    do_stop(1'b0);
    drain();

`ifdef DAC_WAVE_GAIN_EN
    gain = 2'd1;
    pulse_step(1'b1, 1'b0);
    set_mode(2'b00);
    do_start();
    tick();
    drain();
    chk("gain_dac", 32'(dac_value), 32'hBF);
    do_stop(1'b0);
    gain = 2'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
